// File: rtl/conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// conv_window_sequencer
//
// Frame-level controller for the sliding-window line buffer that feeds the
// convolution engine. It accepts a raster pixel stream, gates pushes into the
// line buffer, tracks the row/col of every push, and flags the cycle in which
// the buffer output holds a complete KERNEL_HEIGHT x KERNEL_WIDTH window.
// The buffer's own data-valid is not used; frame start, end and masking of
// stale buffer contents are owned here.
//
// Optional feature: define CONV_SEQ_TLAST_CHK_EN to check i_s_last on every
// push and raise a sticky o_err on mismatch. Without it, i_s_last is ignored
// and o_err is tied low.
//
// Ports
//   i_clk        clock, all logic on rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      frame start pulse, honoured only while idle
//   i_s_data     input pixel
//   i_s_valid    input pixel valid
//   i_s_last     last-pixel-of-frame marker (checked only with the macro)
//   o_s_ready    pixel accepted when i_s_valid & o_s_ready
//   o_buf_data   pixel to the line buffer
//   o_buf_valid  push strobe to the line buffer
//   i_m_ready    consumer can take a window on the next cycle
//   o_win_valid  buffer output holds a complete window this cycle
//   o_win_row    window top row, valid with o_win_valid
//   o_win_col    window left column, valid with o_win_valid
//   o_busy       high while a frame is being filled or run
//   o_done       one-cycle pulse at end of frame
//   o_err        sticky last-marker error (macro only)
// ---------------------------------------------------------------------------
module conv_window_sequencer #(
  parameter int DATA_WIDTH    = 1,
  parameter int KERNEL_WIDTH  = 5,
  parameter int KERNEL_HEIGHT = 5,
  parameter int IMAGE_WIDTH   = 256,
  parameter int IMAGE_HEIGHT  = 256,
  localparam int WIN_ROWS  = IMAGE_HEIGHT - KERNEL_HEIGHT + 1,
  localparam int WIN_COLS  = IMAGE_WIDTH - KERNEL_WIDTH + 1,
  localparam int WIN_ROW_W = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1,
  localparam int WIN_COL_W = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_valid,
  input  logic                  i_s_last,
  output logic                  o_s_ready,
  output logic [DATA_WIDTH-1:0] o_buf_data,
  output logic                  o_buf_valid,
  input  logic                  i_m_ready,
  output logic                  o_win_valid,
  output logic [WIN_ROW_W-1:0]  o_win_row,
  output logic [WIN_COL_W-1:0]  o_win_col,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int ROW_W = $clog2(IMAGE_HEIGHT);
  localparam int COL_W = $clog2(IMAGE_WIDTH);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KERNEL_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KERNEL_WIDTH - 1);
  // The push just before the first complete window ends the fill phase.
  localparam logic [COL_W-1:0] COL_FILL = COL_W'(KERNEL_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  logic push;
  logic at_row_end;
  logic at_frame_end;
  logic at_fill_end;
  logic win_hit;

  // During FILL no window can be produced, so the consumer's ready is
  // irrelevant; in RUN every push may produce a window, so pushes are
  // throttled by i_m_ready and no window is ever dropped.
  assign o_s_ready   = (state == FILL) | ((state == RUN) & i_m_ready);
  assign push        = i_s_valid & o_s_ready;
  assign o_buf_valid = push;
  assign o_buf_data  = i_s_data;
  assign o_busy      = (state == FILL) | (state == RUN);

  assign at_row_end   = (col == COL_LAST);
  assign at_frame_end = at_row_end & (row == ROW_LAST);
  assign at_fill_end  = (row == ROW_WIN) & (col == COL_FILL);
  // Pushes in the first KW-1 columns would give windows straddling two rows.
  assign win_hit      = (row >= ROW_WIN) & (col >= COL_WIN);

  // Frame FSM, push position counters and the registered window/done flags.
  // The window flag lags the push by one cycle to line up with the line
  // buffer's output register. o_done is raised the cycle after DONE so it
  // follows the final window's valid cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      o_win_valid <= 1'b0;
      o_win_row   <= '0;
      o_win_col   <= '0;
      o_done      <= 1'b0;
    end else begin
      o_win_valid <= push & win_hit;
      o_done      <= (state == DONE);
      if (push & win_hit) begin
        o_win_row <= WIN_ROW_W'(row - ROW_WIN);
        o_win_col <= WIN_COL_W'(col - COL_WIN);
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= FILL;
            row   <= '0;
            col   <= '0;
          end
        end
        FILL, RUN: begin
          if (push) begin
            if (at_row_end) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if ((state == FILL) && at_fill_end) begin
              state <= RUN;
            end
            if (at_frame_end) begin
              state <= DONE;
              row   <= '0;
              col   <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_TLAST_CHK_EN
  logic err;

  // Sticky error: set when the last marker disagrees with the frame position
  // of the push, cleared by reset or by the next accepted frame start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err <= 1'b0;
    end else if ((state == IDLE) && i_start) begin
      err <= 1'b0;
    end else if (push && (i_s_last != at_frame_end)) begin
      err <= 1'b1;
    end
  end

  assign o_err = err;
`else
  logic unused_last;

  assign unused_last = i_s_last;
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_window_sequencer
//
// Self-checking bench for conv_window_sequencer with IW=8, IH=6, KW=KH=3 and
// 8-bit pixels whose value is their raster index. A reference model tracks
// the frame purely by counting accepted pixels: a pixel's row and column come
// from its index, windows are derived from that position, and the fill phase
// is the first (KH-1)*IW+KW-1 pixels. Stimulus randomises valid gaps and
// stray start pulses; frames cover plain runs, backpressure, mid-frame reset
// and a misplaced last marker.
// ---------------------------------------------------------------------------
module tb_conv_window_sequencer;

  localparam int DW = 8;
  localparam int KW = 3;
  localparam int KH = 3;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int FRAME_PIX   = IW * IH;
  localparam int FILL_PUSHES = (KH - 1) * IW + KW - 1;
  localparam int WIN_TOTAL   = (IH - KH + 1) * (IW - KW + 1);
  localparam int BUDGET      = 600;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [DW-1:0] i_s_data;
  logic          i_s_valid;
  logic          i_s_last;
  logic          o_s_ready;
  logic [DW-1:0] o_buf_data;
  logic          o_buf_valid;
  logic          i_m_ready;
  logic          o_win_valid;
  logic [1:0]    o_win_row;
  logic [2:0]    o_win_col;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int checkCount;
  int failCount;

  // Reference model state
  bit      mActive;
  int      mPushCount;
  bit      mWinValid;
  int      mWinRow;
  int      mWinCol;
  int      mDoneStage;
  bit      mErr;
  int      winThisFrame;
  logic [DW-1:0] pushed [FRAME_PIX];

  conv_window_sequencer #(
    .DATA_WIDTH   (DW),
    .KERNEL_WIDTH (KW),
    .KERNEL_HEIGHT(KH),
    .IMAGE_WIDTH  (IW),
    .IMAGE_HEIGHT (IH)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_s_data   (i_s_data),
    .i_s_valid  (i_s_valid),
    .i_s_last   (i_s_last),
    .o_s_ready  (o_s_ready),
    .o_buf_data (o_buf_data),
    .o_buf_valid(o_buf_valid),
    .i_m_ready  (i_m_ready),
    .o_win_valid(o_win_valid),
    .o_win_row  (o_win_row),
    .o_win_col  (o_win_col),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  // Free-running clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // A window's pixels, as captured from the push port, must be the raster
  // indices covered by its KH x KW footprint.
  task automatic checkWindowData(input int wr, input int wc);
    for (int dr = 0; dr < KH; dr++) begin
      for (int dc = 0; dc < KW; dc++) begin
        int idx;
        idx = (wr + dr) * IW + wc + dc;
        checkOutput("winData", pushed[idx], idx & 8'hFF);
      end
    end
  endtask

  // Drive one cycle of inputs, check all outputs at the falling edge against
  // the model, then advance the model across the next rising edge.
  task automatic applyStimulus(input logic rstn, input logic start, input logic valid,
                               input logic [DW-1:0] data, input logic last, input logic mready);
    bit expReady;
    bit push;
    bit wasIdle;
    int r;
    int c;
    i_rst_n   = rstn;
    i_start   = start;
    i_s_valid = valid;
    i_s_data  = data;
    i_s_last  = last;
    i_m_ready = mready;
    @(negedge i_clk);
    checkOutput("winValid", o_win_valid, mWinValid);
    if (mWinValid) begin
      checkOutput("winRow", o_win_row, mWinRow);
      checkOutput("winCol", o_win_col, mWinCol);
    end
    checkOutput("done", o_done, mDoneStage == 2);
    checkOutput("busy", o_busy, mActive);
    checkOutput("err", o_err, mErr);
    expReady = mActive && ((mPushCount < FILL_PUSHES) || mready);
    checkOutput("sReady", o_s_ready, expReady);
    checkOutput("bufValid", o_buf_valid, valid && expReady);
    if (valid && expReady) begin
      checkOutput("bufData", o_buf_data, data);
    end
    push = valid && expReady;
    if (!rstn) begin
      mActive    = 1'b0;
      mPushCount = 0;
      mWinValid  = 1'b0;
      mDoneStage = 0;
      mErr       = 1'b0;
    end else begin
      wasIdle    = !mActive && (mDoneStage != 1);
      mDoneStage = (mDoneStage == 1) ? 2 : 0;
      mWinValid  = 1'b0;
      if (push) begin
        r = mPushCount / IW;
        c = mPushCount % IW;
        pushed[mPushCount] = o_buf_data;
        if (r >= KH - 1 && c >= KW - 1) begin
          mWinValid = 1'b1;
          mWinRow   = r - KH + 1;
          mWinCol   = c - KW + 1;
          winThisFrame++;
          checkWindowData(mWinRow, mWinCol);
        end
`ifdef CONV_SEQ_TLAST_CHK_EN
        if (last != (mPushCount == FRAME_PIX - 1)) mErr = 1'b1;
`endif
        mPushCount++;
        if (mPushCount == FRAME_PIX) begin
          mActive    = 1'b0;
          mDoneStage = 1;
        end
      end
      if (start && wasIdle) begin
        mActive      = 1'b1;
        mPushCount   = 0;
        winThisFrame = 0;
        mErr         = 1'b0;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  // One frame: start pulse, then random-gap pixel stream until the done
  // pulse has passed. Optional 5-cycle backpressure, abort by reset at a
  // given pixel, and a stray last marker at a given pixel.
  task automatic runFrame(input int validPct, input bit backpressure, input int abortAt, input int badLastAt);
    int  cycles;
    int  bpLeft;
    bit  bpDone;
    bit  valid;
    bit  start;
    bit  last;
    bit  mready;
    cycles = 0;
    bpLeft = 0;
    bpDone = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    while ((mActive || mDoneStage != 0) && cycles < BUDGET) begin
      cycles++;
      if (abortAt >= 0 && mPushCount == abortAt) begin
        applyStimulus(1'b0, 1'b0, 1'b1, DW'(mPushCount), 1'b0, 1'b1);
        break;
      end
      valid  = ($urandom_range(0, 99) < validPct);
      mready = 1'b1;
      if (backpressure && !bpDone && mPushCount == 30) begin
        bpLeft = 5;
        bpDone = 1'b1;
      end
      if (bpLeft > 0) begin
        mready = 1'b0;
        valid  = 1'b1;
        bpLeft--;
      end
      start = (mDoneStage == 1) || (mActive && ($urandom_range(0, 5) == 0));
      last  = (mPushCount == FRAME_PIX - 1) || (mPushCount == badLastAt);
      applyStimulus(1'b1, start, valid, DW'(mPushCount), last, mready);
    end
    checkOutput("frameTimeout", cycles >= BUDGET, 0);
  endtask

  initial begin
    checkCount   = 0;
    failCount    = 0;
    mActive      = 1'b0;
    mPushCount   = 0;
    mWinValid    = 1'b0;
    mWinRow      = 0;
    mWinCol      = 0;
    mDoneStage   = 0;
    mErr         = 1'b0;
    winThisFrame = 0;
    i_rst_n   = 1'b0;
    i_start   = 1'b0;
    i_s_valid = 1'b0;
    i_s_data  = '0;
    i_s_last  = 1'b0;
    i_m_ready = 1'b1;
    #1;

    $display("[TB] reset and start-during-reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1);

    $display("[TB] full frame, continuous valid");
    runFrame(100, 1'b0, -1, -1);
    checkOutput("winCountFull", winThisFrame, WIN_TOTAL);

    $display("[TB] frame with idle gaps");
    runFrame(60, 1'b0, -1, -1);
    checkOutput("winCountGaps", winThisFrame, WIN_TOTAL);

    $display("[TB] frame with backpressure");
    runFrame(100, 1'b1, -1, -1);
    checkOutput("winCountBp", winThisFrame, WIN_TOTAL);

    $display("[TB] reset at pixel 30, then fresh frame");
    runFrame(100, 1'b0, 30, -1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1);
    runFrame(80, 1'b0, -1, -1);
    checkOutput("winCountAfterAbort", winThisFrame, WIN_TOTAL);

    $display("[TB] stray last marker at pixel 40");
    runFrame(100, 1'b0, -1, 40);
    checkOutput("winCountBadLast", winThisFrame, WIN_TOTAL);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
